dffrf_2r1w_port_sched: RTL
==========================

Name: dffrf_2r1w_port_sched

Overview:
Write-port scheduler and front end for the DFFRF_2R1W register file (combinational-read configuration, USE_LATCH=0). It shares the single write port between two requesters using round-robin arbitration. It sweeps every entry to INIT_VAL after reset or on a CLR request. It passes both read ports through, with bypass of the pending (registered) write so that readers never see stale data.

Parameters:
data_w, 32, data width; must match the register file.
addr_w, 5, address width; the file has 2**addr_w entries.
INIT_VAL, 0, value written to every entry during a sweep.

Ports:
CLK  in  1  clock.
RST  in  1  reset, asynchronous, active-high.
CLR  in  1  request a full re-initialisation sweep.
BUSY  out  1  high while sweeping; requesters stalled.
W0_VAL  in  1  requester 0 write valid.
W0_RDY  out  1  requester 0 write accepted this cycle.
W0_ADDR  in  addr_w  requester 0 write address.
W0_DATA  in  data_w  requester 0 write data.
W1_VAL / W1_RDY / W1_ADDR / W1_DATA  same as W0_*, requester 1.
RF_WE  out  1  register-file write enable (registered).
RF_RW  out  addr_w  register-file write address (registered).
RF_DW  out  data_w  register-file write data (registered).
RA_I, RB_I  in  addr_w  read addresses from consumers.
RA, RB  out  addr_w  read addresses to the register file (equal to RA_I/RB_I, combinational).
DA, DB  in  data_w  read data from the register file.
DA_O, DB_O  out  data_w  read data to consumers, bypassed.

Behaviour:
- Reset (asynchronous):
  - state=SWEEP, ptr=0, rr=0 (requester 0 preferred).
  - RF_WE=0, RF_RW=0, RF_DW=0.
  - BUSY=1, W0_RDY=W1_RDY=0.
- BUSY = (state==SWEEP), combinational from state.
- SWEEP state:
  - Each posedge: RF_WE<=1, RF_RW<=ptr, RF_DW<=INIT_VAL, ptr<=ptr+1.
  - On the edge that issues ptr==2**addr_w-1: state<=RUN, ptr<=0.
  - The sweep lasts exactly 2**addr_w edges. BUSY falls after the last sweep edge.
  - W*_RDY=0 throughout SWEEP.
- RUN state, arbitration (combinational):
  - Only one VAL high -> that requester is granted.
  - Both VAL high -> grant requester rr.
  - RDY is high only for the granted requester, only when CLR=0.
  - Accept = VAL&RDY.
- RUN state, on an accepting edge:
  - RF_WE<=1, RF_RW<=granted ADDR, RF_DW<=granted DATA.
  - rr<=the other requester. rr is updated only on an accept.
- RUN state, no accept: RF_WE<=0; RF_RW/RF_DW hold their values.
- Write latency: the accept edge registers the write; the register file commits it one edge later.
- CLR:
  - Sampled at the posedge in RUN: state<=SWEEP, ptr<=0, no accept that cycle.
  - CLR in SWEEP restarts the sweep at ptr=0.
  - CLR held high keeps restarting the sweep.
- Bypass: DA_O = (RF_WE && RF_RW==RA_I) ? RF_DW : DA. DB_O is the same using RB_I/DB.
  - A read in the cycle after an accept returns the new data.
  - The register file itself returns the new data from the following cycle.
- Same-address writes by both requesters on successive cycles: the later accept wins. No merging.
- Reads during BUSY are undefined for entries not yet swept. Consumers must wait for BUSY=0.
- RST asserted mid-sweep or mid-write: everything returns to reset state immediately. Any registered but uncommitted write is dropped (RF_WE forced 0).

Test Plan:
1. Reset sweep: release RST, with addr_w=5 → exactly 32 edges with RF_WE=1 and RF_RW=0..31 in order, RF_DW=0; BUSY=0 from the 33rd cycle; afterwards every DA_O reads 0.
2. Single requester: W0_VAL=1, ADDR=5, DATA=0xDEADBEEF → W0_RDY=1 the same cycle; next cycle RF_WE=1, RF_RW=5, RF_DW=0xDEADBEEF; RA_I=5 gives DA_O=0xDEADBEEF in that cycle (bypass) and thereafter (from the register file).
3. Contention: W0 and W1 both valid for 4 cycles → grants alternate W0,W1,W0,W1. Then W1 alone → W1 granted. Then both valid → W0 granted (rr points to W0).
4. Bypass on both ports: accept a write to addr 7 with data 0x1234, RA_I=RB_I=7 → DA_O=DB_O=0x1234 in the cycle after accept. Separately, accept a write to addr 8 with RB_I=9 → DB_O reads entry 9 unchanged.
5. CLR mid-traffic: pulse CLR while W0_VAL=1 → W0_RDY=0 that cycle; 32-edge sweep follows; a previously written entry reads 0 afterwards.
6. Reset mid-sweep: assert RST at ptr=10 → RF_WE drops asynchronously; on release the sweep restarts from RF_RW=0.

Source files
------------

// File: rtl/dffrf_2r1w_port_sched.sv
// Write-port scheduler and read front end for the DFFRF_2R1W register file
// (combinational-read configuration). Two requesters share the single write
// port under round-robin arbitration, every entry is swept to INIT_VAL after
// reset or on CLR, and both read ports bypass the registered pending write.
`timescale 1ns/1ps

module dffrf_2r1w_port_sched #(
    parameter int                 data_w   = 32,
    parameter int                 addr_w   = 5,
    parameter logic [data_w-1:0]  INIT_VAL = '0
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              CLR,
    output logic              BUSY,

    input  logic              W0_VAL,
    output logic              W0_RDY,
    input  logic [addr_w-1:0] W0_ADDR,
    input  logic [data_w-1:0] W0_DATA,

    input  logic              W1_VAL,
    output logic              W1_RDY,
    input  logic [addr_w-1:0] W1_ADDR,
    input  logic [data_w-1:0] W1_DATA,

    output logic              RF_WE,
    output logic [addr_w-1:0] RF_RW,
    output logic [data_w-1:0] RF_DW,

    input  logic [addr_w-1:0] RA_I,
    input  logic [addr_w-1:0] RB_I,
    output logic [addr_w-1:0] RA,
    output logic [addr_w-1:0] RB,
    input  logic [data_w-1:0] DA,
    input  logic [data_w-1:0] DB,
    output logic [data_w-1:0] DA_O,
    output logic [data_w-1:0] DB_O
);

    typedef enum logic {
        SWEEP = 1'b0,
        RUN   = 1'b1
    } state_t;

    localparam logic [addr_w-1:0] PTR_LAST = '1;

    state_t            state, state_nxt;
    logic [addr_w-1:0] ptr, ptr_nxt;
    logic              rr, rr_nxt;      // 0: requester 0 preferred on contention
    logic              we_nxt;
    logic [addr_w-1:0] rw_nxt;
    logic [data_w-1:0] dw_nxt;
    logic              gsel;            // granted requester index when any is valid
    logic              accept;

    // State register: FSM state, sweep pointer, round-robin bit and the
    // registered write port, all cleared asynchronously.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= SWEEP;
            ptr   <= '0;
            rr    <= 1'b0;
            RF_WE <= 1'b0;
            RF_RW <= '0;
            RF_DW <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values computed by the combinational processes.
            state <= state_nxt;
            ptr   <= ptr_nxt;
            rr    <= rr_nxt;
            RF_WE <= we_nxt;
            RF_RW <= rw_nxt;
            RF_DW <= dw_nxt;
        end
    end

    // Next-state logic: sweep sequencing, CLR restart and write registration.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves a variable unassigned and no latch is inferred.
        state_nxt = state;
        ptr_nxt   = ptr;
        rr_nxt    = rr;
        we_nxt    = 1'b0;
        rw_nxt    = RF_RW;
        dw_nxt    = RF_DW;
        case (state)
            SWEEP: begin
                if (CLR) begin
                    // Restart from entry 0; no write is issued on this edge.
                    ptr_nxt = '0;
                end else begin
                    we_nxt  = 1'b1;
                    rw_nxt  = ptr;
                    dw_nxt  = INIT_VAL;
                    ptr_nxt = ptr + 1'b1;
                    if (ptr == PTR_LAST) begin
                        state_nxt = RUN;
                        ptr_nxt   = '0;
                    end
                end
            end
            RUN: begin
                if (CLR) begin
                    state_nxt = SWEEP;
                    ptr_nxt   = '0;
                end else if (accept) begin
                    we_nxt = 1'b1;
                    rw_nxt = gsel ? W1_ADDR : W0_ADDR;
                    dw_nxt = gsel ? W1_DATA : W0_DATA;
                    rr_nxt = ~gsel;
                end
            end
            default: state_nxt = SWEEP;
        endcase
    end

    // Output logic: busy flag and round-robin grant, stalled during a sweep
    // and on any cycle where CLR is requested.
    always_comb begin
        BUSY   = (state == SWEEP);
        gsel   = (W0_VAL && W1_VAL) ? rr : W1_VAL;
        W0_RDY = (state == RUN) && !CLR && W0_VAL && !gsel;
        W1_RDY = (state == RUN) && !CLR && W1_VAL &&  gsel;
    end

    assign accept = (W0_VAL && W0_RDY) || (W1_VAL && W1_RDY);

    // Read front end: addresses pass straight through; the pending write is
    // forwarded so a read the cycle after an accept already sees new data.
    assign RA   = RA_I;
    assign RB   = RB_I;
    assign DA_O = (RF_WE && (RF_RW == RA_I)) ? RF_DW : DA;
    assign DB_O = (RF_WE && (RF_RW == RB_I)) ? RF_DW : DB;

endmodule
